mem_arbiter: RTL

Two-port arbiter that shares the single unified instruction/data memory of the multicycle core between the core's memory port (requester 0) and a program loader/debug port (requester 1). It accepts one request at a time, latches address, write data and direction, drives the memory for a fixed number of wait states, captures read data, and returns a one-cycle completion pulse to the winner. Priority is round-robin, with a per-port lock for atomic read-modify-write sequences.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_pick2.sv | 25 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port indices and lock-owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arbState_t;

  localparam logic P_CORE = 1'b0;
  localparam logic P_LDR  = 1'b1;

  // Bit 1 marks a valid owner, bit 0 carries the owning port index.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b10,
    OWN_P1   = 2'b11
  } owner_t;

  function automatic owner_t ownerOf(input logic idx);
    return idx ? OWN_P1 : OWN_P0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way picker: a live lock owner wins a tie, otherwise the port not served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic owner_valid,
  input  logic owner,
  output logic valid,
  output logic index
);

  assign valid = req0 | req1;

  always_comb begin
    index = P_CORE;
    if (req0 && req1) begin
      index = owner_valid ? owner : ~last;
    end else if (req1) begin
      index = P_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one unified memory between the core port (0) and the loader/debug port (1),
// one access at a time with a fixed number of wait states and round-robin/lock arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  arbState_t     r_state;
  arbState_t     w_next;
  owner_t        r_owner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic          r_idx;
  logic          r_last;

  logic          w_reqOwner;
  logic          w_lockOwner;
  logic          w_ownerLive;
  logic          w_pickValid;
  logic          w_pickIdx;
  logic          w_lockIdx;

  // The owner only keeps priority while it is still requesting with its lock held.
  assign w_reqOwner  = r_owner[0] ? req1 : req0;
  assign w_lockOwner = r_owner[0] ? lock1 : lock0;
  assign w_ownerLive = r_owner[1] & w_reqOwner & w_lockOwner;
  assign w_lockIdx   = r_idx ? lock1 : lock0;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last        (r_last),
    .owner_valid (w_ownerLive),
    .owner       (r_owner[0]),
    .valid       (w_pickValid),
    .index       (w_pickIdx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          gnt0   = (w_pickIdx == P_CORE);
          gnt1   = (w_pickIdx == P_LDR);
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done0  = (r_idx == P_CORE);
        done1  = (r_idx == P_LDR);
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= P_CORE;
      r_last  <= P_LDR;
      r_owner <= OWN_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_ownerLive) begin
            r_owner <= OWN_NONE;
          end
          if (w_pickValid) begin
            r_idx   <= w_pickIdx;
            r_we    <= w_pickIdx ? we1 : we0;
            r_addr  <= w_pickIdx ? addr1 : addr0;
            r_wdata <= w_pickIdx ? wdata1 : wdata0;
            r_cnt   <= WAIT_CNT;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_last  <= r_idx;
          r_owner <= w_lockIdx ? ownerOf(r_idx) : OWN_NONE;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_re    = (r_state == ACCESS) & ~r_we;
  assign mem_we    = (r_state == ACCESS) & r_we;
  assign rdata     = r_rdata;

endmodule
